// File: rtl/alu_pkg.sv
// Shared types for the ALU vector checker: ALU function codes and checker FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        AND  = 3'd0,
        OR   = 3'd1,
        ADD  = 3'd2,
        SLTU = 3'd3,
        ANDN = 3'd4,
        ORN  = 3'd5,
        SUB  = 3'd6,
        SLT  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DONE
    } state_e;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU under test: logic ops, wrapping add/sub, signed and unsigned set-less-than.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          f,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    // NOTE: y gets a default before the case so no path through this block can infer a latch.
    always_comb begin
        y = '0;
        case (f)
            AND:     y = a & b;
            OR:      y = a | b;
            ADD:     y = a + b;
            SLTU:    y = {{(WIDTH-1){1'b0}}, (a < b)};
            ANDN:    y = a & ~b;
            ORN:     y = a | ~b;
            SUB:     y = a - b;
            SLT:     y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/alu_vector_checker.sv
// Accepts one test vector at a time, runs it through the ALU from registered operands,
// and keeps vector/error counts plus a record of the first failing vector.
module alu_vector_checker
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [2:0]       vec_f,
    input  logic [WIDTH-1:0] vec_a,
    input  logic [WIDTH-1:0] vec_b,
    input  logic [WIDTH-1:0] vec_y_exp,
    input  logic             vec_zero_exp,
    input  logic             vec_last,
    input  logic             clear,
    output logic [31:0]      vectornum,
    output logic [31:0]      errors,
    output logic             err_pulse,
    output logic [31:0]      first_fail_idx,
    output logic [WIDTH-1:0] first_fail_y,
    output logic             done,
    output logic             pass
);

    state_e           state_q, state_d;
    alu_op_e          op_q;
    logic [WIDTH-1:0] a_q, b_q, y_exp_q;
    logic             zero_exp_q, last_q;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             accept;
    logic             mismatch;

    assign accept   = vec_valid && vec_ready;
    assign mismatch = (y != y_exp_q) || (zero != zero_exp_q);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (vec_valid) state_d = CHECK;
            CHECK:   state_d = last_q ? DONE : IDLE;
            DONE:    if (clear) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vec_ready = (state_q == IDLE);
        done      = (state_q == DONE);
        pass      = (state_q == DONE) && (errors == '0);
    end

    // NOTE: the vector holding registers carry no reset; they are only read in CHECK, after a load.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q       <= alu_op_e'(vec_f);
            a_q        <= vec_a;
            b_q        <= vec_b;
            y_exp_q    <= vec_y_exp;
            zero_exp_q <= vec_zero_exp;
            last_q     <= vec_last;
        end
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .a    (a_q),
        .b    (b_q),
        .f    (op_q),
        .y    (y),
        .zero (zero)
    );

    // Scoreboard counters: updated on the CHECK edge, wiped by reset or by clear in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            vectornum      <= '0;
            errors         <= '0;
            err_pulse      <= 1'b0;
            first_fail_idx <= '0;
            first_fail_y   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (state_q == CHECK) begin
                if (vectornum != CNT_MAX) vectornum <= vectornum + 32'd1;
                if (mismatch) begin
                    err_pulse <= 1'b1;
                    if (errors != CNT_MAX) errors <= errors + 32'd1;
                    if (errors == '0) begin
                        first_fail_idx <= vectornum;
                        first_fail_y   <= y;
                    end
                end
            end else if (state_q == DONE && clear) begin
                vectornum      <= '0;
                errors         <= '0;
                first_fail_idx <= '0;
                first_fail_y   <= '0;
            end
        end
    end

endmodule
